// File: rtl/ex_muldiv_ctrl_pkg.sv
// rtl/ex_muldiv_ctrl_pkg.sv - shared types for the RV32M multiply/divide sequencer
package ex_muldiv_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   function automatic logic op_is_div(input muldiv_op_t op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_iter_core.sv
// rtl/ex_muldiv_ctrl_iter_core.sv - one shift-add multiply or restoring divide step
module muldiv_iter_core #(
   parameter int XLEN = 32
) (
   input  logic            i_is_div,
   input  logic [XLEN-1:0] i_hi,
   input  logic [XLEN-1:0] i_lo,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN:0] w_sum;
   logic [XLEN:0] w_shifted;
   logic [XLEN:0] w_diff;

   // hi:lo is the product for multiply, remainder:quotient for divide
   always_comb begin
      w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : {(XLEN+1){1'b0}});
      w_shifted = {i_hi, i_lo[XLEN-1]};
      w_diff    = w_shifted - {1'b0, i_b};
      if (i_is_div) begin
         if (w_diff[XLEN]) begin
            o_hi = w_shifted[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], 1'b0};
         end else begin
            o_hi = w_diff[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], 1'b1};
         end
      end else begin
         o_hi = w_sum[XLEN:1];
         o_lo = {w_sum[0], i_lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - iterative RV32M multiply/divide sequencer beside the EX ALU
module ex_muldiv_ctrl
   import ex_muldiv_ctrl_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  op_a,
   input  logic [XLEN-1:0]  op_b,
   input  logic [TAG_W-1:0] rd_in,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] rd_out
);

   localparam int CW = $clog2(XLEN);

   muldiv_state_t    r_state, w_state_nxt;
   muldiv_op_t       r_op, w_op_in;
   logic [CW-1:0]    r_cnt;
   logic [XLEN-1:0]  r_hi, r_lo, r_b;
   logic             r_a_neg, r_b_neg;
   logic [TAG_W-1:0] r_rd;

   logic              w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic              w_div0, w_ovf, w_special;
   logic [XLEN-1:0]   w_a_mag, w_b_mag, w_hi_nxt, w_lo_nxt;
   logic [XLEN-1:0]   w_quot_fix, w_rem_fix, w_sel;
   logic [2*XLEN-1:0] w_prod, w_prod_fix;

   assign w_op_in  = muldiv_op_t'(funct3);
   assign w_accept = (r_state == IDLE) && start && !flush;

   always_comb begin
      w_a_signed = 1'b0;
      w_b_signed = 1'b0;
      case (w_op_in)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            w_a_signed = 1'b1;
            w_b_signed = 1'b1;
         end
         OP_MULHSU: w_a_signed = 1'b1;
         default:   ;
      endcase
   end

   assign w_a_neg   = w_a_signed & op_a[XLEN-1];
   assign w_b_neg   = w_b_signed & op_b[XLEN-1];
   assign w_a_mag   = w_a_neg ? -op_a : op_a;
   assign w_b_mag   = w_b_neg ? -op_b : op_b;
   assign w_div0    = op_is_div(w_op_in) && (op_b == '0);
   assign w_ovf     = ((w_op_in == OP_DIV) || (w_op_in == OP_REM)) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
   assign w_special = w_div0 | w_ovf;

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .i_is_div (op_is_div(r_op)),
      .i_hi     (r_hi),
      .i_lo     (r_lo),
      .i_b      (r_b),
      .o_hi     (w_hi_nxt),
      .o_lo     (w_lo_nxt)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_op    <= OP_MUL;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_b     <= '0;
         r_a_neg <= 1'b0;
         r_b_neg <= 1'b0;
         r_rd    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op  <= w_op_in;
            r_rd  <= rd_in;
            r_b   <= w_b_mag;
            r_cnt <= CW'(XLEN-1);
            // Special cases preload quotient/remainder so the DONE mux needs no extra path
            if (w_special) begin
               r_hi    <= w_div0 ? op_a : '0;
               r_lo    <= w_div0 ? '1 : op_a;
               r_a_neg <= 1'b0;
               r_b_neg <= 1'b0;
            end else begin
               r_hi    <= '0;
               r_lo    <= w_a_mag;
               r_a_neg <= w_a_neg;
               r_b_neg <= w_b_neg;
            end
         end else if (r_state == CALC) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign w_prod     = {r_hi, r_lo};
   assign w_prod_fix = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
   assign w_quot_fix = (r_a_neg ^ r_b_neg) ? -r_lo : r_lo;
   assign w_rem_fix  = r_a_neg ? -r_hi : r_hi;

   always_comb begin
      case (r_op)
         OP_MUL:                      w_sel = w_prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_sel = w_prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             w_sel = w_quot_fix;
         default:                     w_sel = w_rem_fix;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      stall       = 1'b0;
      done        = 1'b0;
      result      = '0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               stall       = 1'b1;
               w_state_nxt = w_special ? DONE : CALC;
            end
         end
         CALC: begin
            stall = 1'b1;
            if (r_cnt == '0) w_state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            result      = w_sel;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (flush) w_state_nxt = IDLE;
   end

   assign rd_out = r_rd;

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Iterative RV32M multiply/divide sequencer attached beside the Execute-stage ALU. It accepts one M-extension operation from the ID/EX boundary and runs a radix-2 shift-add multiply or a restoring divide over XLEN cycles. While busy it stalls the front of the pipeline. On completion it presents a one-cycle result with its destination register tag to EX/MEM.

Parameters:
XLEN, 32, operand/result width; must be a power of two ≥ 8.
TAG_W, 5, width of the destination-register tag carried through.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (asserted when 0)
start  input  1  operation valid from ID/EX; sampled only in IDLE
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value
op_b  input  XLEN  rs2 value
rd_in  input  TAG_W  destination register of the issued op
flush  input  1  kill in-flight op (branch mispredict/redirect)
stall  output  1  hold IF/ID/EX registers
done  output  1  one-cycle pulse: result and rd_out valid
result  output  XLEN  final result; 0 when done=0
rd_out  output  TAG_W  captured rd_in; held until next accept

Behaviour:
- States: IDLE, CALC, DONE. Counter: $clog2(XLEN) bits.
- Reset (reset==0 at an edge): state=IDLE, counter=0, internal accumulators=0, done=0, result=0, rd_out=0, stall=0.
- Accept: state==IDLE and start==1 and flush==0. At this edge:
  - Capture op, rd_in, and sign flags.
  - Capture operand magnitudes: absolute value for signed ops, raw value for unsigned ops. For MULHSU, only op_a is signed.
- stall = (state==IDLE & start & ~flush) | (state==CALC). stall is 0 in DONE.
- Special cases, decided at accept, go straight to DONE with no CALC:
  - Division by zero: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow, op_a=-2^(XLEN-1) and op_b=-1: DIV → op_a; REM → 0.
- Normal ops go to CALC with counter=XLEN-1. Each CALC cycle performs one iteration:
  - Multiply: conditional add of the multiplicand into a 2·XLEN product, then shift.
  - Divide: shift remainder/quotient, trial-subtract, restore.
  - counter decrements; at counter==0 go to DONE.
- Latency, counted from the accept edge to the edge that enters DONE:
  - Normal ops: XLEN+1 edges (33 for XLEN=32).
  - Special cases: 1 edge.
  - done is high for exactly one cycle in DONE, then the FSM returns to IDLE.
  - A start in the DONE cycle is ignored; the issuer holds start until it sees stall.
- Sign fix is applied combinationally in DONE:
  - MUL/MULH/MULHSU: negate the product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ.
  - REM: remainder takes the sign of op_a.
- Result select:
  - MUL → low XLEN bits.
  - MULH/MULHSU/MULHU → high XLEN bits.
  - DIV/DIVU → quotient.
  - REM/REMU → remainder.
- flush: from any state, the next state is IDLE and done is suppressed. It beats start in the same cycle. flush in the DONE cycle does not retract the done already visible.
- reset mid-CALC: abort immediately; no done pulse.
- start while CALC: ignored, no queuing.
- All arithmetic is unsigned on magnitudes. Two's-complement negate wraps at XLEN bits.

Decomposition:
- Add to the shared types header:
  - muldiv_op_t enum with the eight funct3 encodings above.
  - muldiv_state_t {IDLE, CALC, DONE}.
- One natural sub-module: muldiv_iter_core. It is the combinational single-iteration step for both shift-add and restoring divide, selected by an is_div input. ex_muldiv_ctrl owns the FSM, counter, registers, special-case logic and sign fix.

Test Plan:
- MUL 7×-3 (op_b=0xFFFFFFFD), rd_in=5 → stall high 33 cycles; done 1 cycle later with result=0xFFFFFFEB, rd_out=5.
- MULH 0x80000000×0x80000000 → result=0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU -1×2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with done on the cycle after accept and no CALC:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000; REM → 0.
- flush asserted 10 cycles into a DIVU → IDLE next cycle, stall=0, no done. A new MUL 3×4 then completes with 12.
- reset=0 mid-CALC, then a second start asserted while CALC → all outputs 0 after reset. After re-accept, the start during CALC is ignored: exactly one done results.
